core_ctrl: RTL

- Sequencer that drives the 19-bit core instruction word for one complete attention pass.
- Pass order: write Q rows, write K rows, load K into the MAC array, pad, execute Q, drain the ofifo into psum memory, then normalize through the SFP row (accumulate, then divide with write-back).
- Sits between the testbench/host data source and the core; it is the only producer of `inst`.

---
 rtl/core_ctrl_pkg.sv | 59 +++++
 rtl/core_ctrl_inst_enc.sv | 97 +++++++++
 rtl/core_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/core_ctrl_pkg.sv
// Shared types and constants for the attention-pass sequencer core_ctrl.
// Optional feature macro: CORE_CTRL_NORM_EN (enables the ACC/DIV normalization states).
package core_ctrl_pkg;

  localparam int INST_W       = 19;
  localparam int CNT_W        = 8;
  localparam int ADDR_FIELD_W = 4;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Instruction word bit positions.
  localparam int B_SFP_DIV  = 18;
  localparam int B_SFP_ACC  = 17;
  localparam int B_OFIFO_RD = 16;
  localparam int B_QK_ADDR  = 12;
  localparam int B_PS_ADDR  = 8;
  localparam int B_EXEC     = 7;
  localparam int B_LOAD     = 6;
  localparam int B_QMEM_RD  = 5;
  localparam int B_QMEM_WR  = 4;
  localparam int B_KMEM_RD  = 3;
  localparam int B_KMEM_WR  = 2;
  localparam int B_PMEM_RD  = 1;
  localparam int B_PMEM_WR  = 0;

`ifdef CORE_CTRL_NORM_EN
  localparam logic NORM_EN = 1'b1;
`else
  localparam logic NORM_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    Q_WR  = 4'd1,
    K_WR  = 4'd2,
    K_LD  = 4'd3,
    PAD   = 4'd4,
    Q_EX  = 4'd5,
    DRAIN = 4'd6,
    ACC   = 4'd7,
    DIV   = 4'd8,
    DONE  = 4'd9
  } state_t;

  // Place the low aw bits of a counter into a 4-bit address field; upper bits stay 0.
  function automatic logic [ADDR_FIELD_W-1:0] addr_field(input logic [CNT_W-1:0] c, input int aw);
    logic [ADDR_FIELD_W-1:0] f;
    f = '0;
    for (int i = 0; i < ADDR_FIELD_W; i++) begin
      if (i < aw) begin
        f[i] = c[i];
      end else begin
        f[i] = 1'b0;
      end
    end
    return f;
  endfunction

endpackage

// File: rtl/core_ctrl_inst_enc.sv
// Combinational decode of sequencer state/counters into the 19-bit core instruction.
// Normalization bits [18:17] depend on CORE_CTRL_NORM_EN and are 0 when it is undefined.
module core_ctrl_inst_enc
  import core_ctrl_pkg::*;
#(
  parameter int NUM_Q  = 8,
  parameter int NUM_K  = 8,
  parameter int ADDR_W = 4
) (
  input  state_t             state,
  input  logic [CNT_W-1:0]   cnt,
  input  logic               phase,
  input  logic               pend,
  input  logic               rd_allow,
  input  logic               data_valid,
  input  logic               fifo_valid,
  output logic [INST_W-1:0]  inst
);

  logic [ADDR_FIELD_W-1:0] a;

  assign a = addr_field(cnt, ADDR_W);

  // Build the instruction word for the current state; strobes carry their address only while active.
  always_comb begin
    inst = '0;
    case (state)
      Q_WR: begin
        if (data_valid) begin
          inst[B_QMEM_WR] = 1'b1;
          inst[B_QK_ADDR +: ADDR_FIELD_W] = a;
        end else begin
          inst[B_QMEM_WR] = 1'b0;
        end
      end
      K_WR: begin
        if (data_valid) begin
          inst[B_KMEM_WR] = 1'b1;
          inst[B_QK_ADDR +: ADDR_FIELD_W] = a;
        end else begin
          inst[B_KMEM_WR] = 1'b0;
        end
      end
      K_LD: begin
        inst[B_LOAD] = 1'b1;
        // The extra final cycle only covers the K SRAM read latency.
        if (cnt < CNT_W'(NUM_K)) begin
          inst[B_KMEM_RD] = 1'b1;
          inst[B_QK_ADDR +: ADDR_FIELD_W] = a;
        end else begin
          inst[B_KMEM_RD] = 1'b0;
        end
      end
      Q_EX: begin
        inst[B_EXEC] = 1'b1;
        if (cnt < CNT_W'(NUM_Q)) begin
          inst[B_QMEM_RD] = 1'b1;
          inst[B_QK_ADDR +: ADDR_FIELD_W] = a;
        end else begin
          inst[B_QMEM_RD] = 1'b0;
        end
      end
      DRAIN: begin
        inst[B_OFIFO_RD] = fifo_valid & rd_allow;
        // A row read last cycle is written to psum memory now.
        if (pend) begin
          inst[B_PMEM_WR] = 1'b1;
          inst[B_PS_ADDR +: ADDR_FIELD_W] = a;
        end else begin
          inst[B_PMEM_WR] = 1'b0;
        end
      end
      ACC: begin
        if (cnt < CNT_W'(NUM_Q)) begin
          inst[B_PMEM_RD] = 1'b1;
          inst[B_PS_ADDR +: ADDR_FIELD_W] = a;
        end else begin
          inst[B_PMEM_RD] = 1'b0;
        end
        inst[B_SFP_ACC] = NORM_EN & (cnt != '0);
      end
      DIV: begin
        inst[B_PS_ADDR +: ADDR_FIELD_W] = a;
        if (phase) begin
          inst[B_SFP_DIV] = NORM_EN;
          inst[B_PMEM_WR] = 1'b1;
        end else begin
          inst[B_PMEM_RD] = 1'b1;
        end
      end
      default: begin
        inst = '0;
      end
    endcase
  end

endmodule

// File: rtl/core_ctrl.sv
// Attention-pass sequencer: Q write, K write, K load, pad, Q execute, drain,
// and optional SFP normalization (enabled by macro CORE_CTRL_NORM_EN).
module core_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int NUM_Q   = 8,
  parameter int NUM_K   = 8,
  parameter int ADDR_W  = 4,
  parameter int PAD_CYC = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              data_valid,
  output logic              data_ready,
  input  logic              fifo_valid,
  output logic [INST_W-1:0] inst,
  output logic              busy,
  output logic              done
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] rd_cnt;
  logic             phase;
  logic             pend;
  logic             rd_allow;
  logic             ofifo_rd;

  // Never pull more rows from the ofifo than the pass will write back.
  assign rd_allow = (rd_cnt < CNT_W'(NUM_Q));
  assign ofifo_rd = inst[B_OFIFO_RD];

  assign data_ready = (state == Q_WR) || (state == K_WR);
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);

  core_ctrl_inst_enc #(
    .NUM_Q (NUM_Q),
    .NUM_K (NUM_K),
    .ADDR_W(ADDR_W)
  ) u_enc (
    .state     (state),
    .cnt       (cnt),
    .phase     (phase),
    .pend      (pend),
    .rd_allow  (rd_allow),
    .data_valid(data_valid),
    .fifo_valid(fifo_valid),
    .inst      (inst)
  );

  // Pass sequencing FSM; every counter is cleared when its state is entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      rd_cnt <= '0;
      phase  <= 1'b0;
      pend   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= Q_WR;
            cnt   <= '0;
          end
        end
        Q_WR: begin
          if (data_valid) begin
            if (cnt == CNT_W'(NUM_Q - 1)) begin
              state <= K_WR;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
        end
        K_WR: begin
          if (data_valid) begin
            if (cnt == CNT_W'(NUM_K - 1)) begin
              state <= K_LD;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
        end
        K_LD: begin
          if (cnt == CNT_W'(NUM_K)) begin
            state <= PAD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        PAD: begin
          if (cnt == CNT_W'(PAD_CYC - 1)) begin
            state <= Q_EX;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        Q_EX: begin
          if (cnt == CNT_W'(NUM_Q)) begin
            state  <= DRAIN;
            cnt    <= '0;
            rd_cnt <= '0;
            pend   <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        DRAIN: begin
          pend <= ofifo_rd;
          if (ofifo_rd) begin
            rd_cnt <= rd_cnt + CNT_ONE;
          end
          if (pend) begin
            if (cnt == CNT_W'(NUM_Q - 1)) begin
`ifdef CORE_CTRL_NORM_EN
              state <= ACC;
`else
              state <= DONE;
`endif
              cnt  <= '0;
              pend <= 1'b0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
        end
        ACC: begin
          if (cnt == CNT_W'(NUM_Q)) begin
            state <= DIV;
            cnt   <= '0;
            phase <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        DIV: begin
          if (!phase) begin
            phase <= 1'b1;
          end else begin
            phase <= 1'b0;
            if (cnt == CNT_W'(NUM_Q - 1)) begin
              state <= DONE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          cnt   <= '0;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
